// File: rtl/ser_par_lane_sched.sv
// Round-robin scheduler that lends one shared serial-to-parallel converter to N_LANES
// serial sources for a whole word at a time and presents each word on a valid/ready register.
module ser_par_lane_sched #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = 2,
  parameter int WORD_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_LANES-1:0] req_i,
  input  logic [N_LANES-1:0] din_i,
  output logic [N_LANES-1:0] gnt_o,
  output logic               conv_en_o,
  output logic               conv_din_o,
  input  logic [WORD_W-1:0]  conv_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WORD_W-1:0]  out_data_o,
  output logic [LANE_W-1:0]  out_lane_o,
  output logic               busy_o,
  output logic               proto_err_o
);

  localparam int CNT_W = $clog2(WORD_W);

  // state   | meaning
  // IDLE    | waiting for any req, round-robin pick from ptr
  // SHIFT   | granted lane streams WORD_W bits into the converter
  // CAPTURE | converter holds the word; load output register when free
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_e;

  state_e             state_q, state_d;
  logic [LANE_W-1:0]  ptr_q, ptr_d;
  logic [LANE_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic [LANE_W-1:0]  out_lane_q, out_lane_d;
  logic               proto_err_q, proto_err_d;

  logic [LANE_W-1:0]  pick;
  logic               pick_vld;
  logic [LANE_W-1:0]  idx;
  logic [LANE_W-1:0]  sel_next;
  logic               load;

  // Descending search so the lane closest to ptr is the last (winning) assignment.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      idx = LANE_W'((int'(ptr_q) + i) % N_LANES);
      if (req_i[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign load     = (state_q == CAPTURE) && (!out_valid_q || out_ready_i);
  assign sel_next = (sel_q == LANE_W'(N_LANES - 1)) ? '0 : sel_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_vld) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == CNT_W'(WORD_W - 1)) state_d = CAPTURE;
      CAPTURE: if (load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o      = '0;
    conv_en_o  = 1'b0;
    conv_din_o = 1'b0;
    if (state_q == SHIFT) begin
      gnt_o[sel_q] = 1'b1;
      conv_en_o    = 1'b1;
      conv_din_o   = din_i[sel_q];
    end
  end

  assign busy_o = (state_q != IDLE);

  always_comb begin
    sel_d       = (state_q == IDLE && pick_vld) ? pick : sel_q;
    bit_cnt_d   = (state_q == SHIFT) ? bit_cnt_q + 1'b1 : '0;
    ptr_d       = load ? sel_next : ptr_q;
    // A simultaneous accept and reload keeps valid high with the new word.
    out_valid_d = load | (out_valid_q & ~out_ready_i);
    out_data_d  = load ? conv_data_i : out_data_q;
    out_lane_d  = load ? sel_q : out_lane_q;
    proto_err_d = proto_err_q | ((state_q == SHIFT) & ~req_i[sel_q]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      sel_q       <= '0;
      bit_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      bit_cnt_q   <= bit_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_lane_o  = out_lane_q;
  assign proto_err_o = proto_err_q;

endmodule
